// File: rtl/a80_bus_pkg.sv
// rtl/a80_bus_pkg.sv - shared types and constants for the A-Z80 segmented data bus
package a80_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_TURN = 2'd3
  } sw_state_t;

  // Zero-extended so any bus width can take its low bits as the default mask.
  localparam logic [31:0] A80_DEFAULT_MASK = 32'h0000_0038;

endpackage

// File: rtl/bus_sw_fsm.sv
// rtl/bus_sw_fsm.sv - grant FSM, turnaround counter and sticky error for one bus switch
module bus_sw_fsm
  import a80_bus_pkg::*;
#(
  parameter int TURNAROUND = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req_u,
  input  logic i_req_d,
  input  logic i_cont,
  output logic o_grant_u,
  output logic o_grant_d,
  output logic o_err
);

  localparam logic [2:0] TA_LOAD = (TURNAROUND > 0) ? 3'(TURNAROUND - 1) : 3'd0;

  sw_state_t  r_state;
  sw_state_t  w_next;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_next;
  logic       w_conflict;

  assign w_conflict = i_req_u & i_req_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      o_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      o_err   <= o_err | w_conflict | i_cont;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    if (w_conflict) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_u)      w_next = ST_UP;
          else if (i_req_d) w_next = ST_DOWN;
        end
        ST_UP: begin
          if (i_req_d) begin
            if (TURNAROUND == 0) begin
              w_next = ST_DOWN;
            end else begin
              w_next     = ST_TURN;
              w_cnt_next = TA_LOAD;
            end
          end else if (!i_req_u) begin
            w_next = ST_IDLE;
          end
        end
        ST_DOWN: begin
          if (i_req_u) begin
            if (TURNAROUND == 0) begin
              w_next = ST_UP;
            end else begin
              w_next     = ST_TURN;
              w_cnt_next = TA_LOAD;
            end
          end else if (!i_req_d) begin
            w_next = ST_IDLE;
          end
        end
        ST_TURN: begin
          // Dead time: the direction is decided only by the request present when the count expires.
          if (r_cnt != 3'd0) w_cnt_next = r_cnt - 3'd1;
          else if (i_req_u)  w_next = ST_UP;
          else if (i_req_d)  w_next = ST_DOWN;
          else               w_next = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  assign o_grant_u = (r_state == ST_UP);
  assign o_grant_d = (r_state == ST_DOWN);

endmodule

// File: rtl/bus_switch_seg.sv
// rtl/bus_switch_seg.sv - registered NSEG-switch data-bus splitter with keepers and contention detect
module bus_switch_seg
  import a80_bus_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               NSEG       = 2,
  parameter logic [WIDTH-1:0] MASK       = WIDTH'(A80_DEFAULT_MASK),
  parameter int               TURNAROUND = 1,
  parameter logic [WIDTH-1:0] KEEP_RST   = {WIDTH{1'b1}}
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NSEG-1:0]           ctl_sw_u,
  input  logic [NSEG-1:0]           ctl_sw_d,
  input  logic [NSEG-1:0]           ctl_sw_mask_en,
  input  logic [NSEG:0]             seg_drv,
  input  logic [(NSEG+1)*WIDTH-1:0] seg_in,
  output logic [(NSEG+1)*WIDTH-1:0] seg_out,
  output logic [NSEG-1:0]           bus_sw_u,
  output logic [NSEG-1:0]           bus_sw_d,
  output logic [NSEG-1:0]           sw_err
);

  logic [WIDTH-1:0] r_keep [NSEG+1];
  logic [WIDTH-1:0] w_dv   [NSEG+1];
  logic [WIDTH-1:0] w_uv   [NSEG+1];
  logic [NSEG:0]    w_dnb;
  logic [NSEG:0]    w_unb;
  logic [NSEG:0]    w_multi;
  logic [NSEG-1:0]  w_cont;

  assign w_dnb = {bus_sw_d, 1'b0};
  assign w_unb = {1'b0, bus_sw_u};

  // An undriven, unfed segment offers its keeper value, so w_dv/w_uv fall back to r_keep.
  always_comb begin
    w_dv[0] = seg_drv[0] ? seg_in[0 +: WIDTH] : r_keep[0];
    for (int k = 1; k <= NSEG; k++) begin
      if (seg_drv[k])
        w_dv[k] = seg_in[k*WIDTH +: WIDTH];
      else if (bus_sw_d[k-1])
        w_dv[k] = w_dv[k-1] & ~(ctl_sw_mask_en[k-1] ? MASK : {WIDTH{1'b0}});
      else
        w_dv[k] = r_keep[k];
    end
  end

  always_comb begin
    w_uv[NSEG] = seg_drv[NSEG] ? seg_in[NSEG*WIDTH +: WIDTH] : r_keep[NSEG];
    for (int k = NSEG - 1; k >= 0; k--) begin
      if (seg_drv[k])       w_uv[k] = seg_in[k*WIDTH +: WIDTH];
      else if (bus_sw_u[k]) w_uv[k] = w_uv[k+1];
      else                  w_uv[k] = r_keep[k];
    end
  end

  for (genvar g = 0; g <= NSEG; g++) begin : g_seg
    assign seg_out[g*WIDTH +: WIDTH] = (seg_drv[g] | w_dnb[g]) ? w_dv[g] : w_uv[g];
  end

  // Blame only the switches actually driving into a multiply-sourced segment.
  assign w_multi = (seg_drv & w_dnb) | (seg_drv & w_unb) | (w_dnb & w_unb);
  assign w_cont  = (w_multi[NSEG:1] & bus_sw_d) | (w_multi[NSEG-1:0] & bus_sw_u);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= NSEG; k++) r_keep[k] <= KEEP_RST;
    end else begin
      for (int k = 0; k <= NSEG; k++) r_keep[k] <= seg_out[k*WIDTH +: WIDTH];
    end
  end

  for (genvar i = 0; i < NSEG; i++) begin : g_sw
    bus_sw_fsm #(
      .TURNAROUND(TURNAROUND)
    ) u_fsm (
      .i_clk    (clk),
      .i_rst    (reset),
      .i_req_u  (ctl_sw_u[i]),
      .i_req_d  (ctl_sw_d[i]),
      .i_cont   (w_cont[i]),
      .o_grant_u(bus_sw_u[i]),
      .o_grant_d(bus_sw_d[i]),
      .o_err    (sw_err[i])
    );
  end

endmodule
